xip_line_cache: RTL and testbench
=================================

Name: xip_line_cache

Overview:
- Read-only, direct-mapped instruction line cache between the CPU-side AHB-Lite bus and the QSPI XIP flash controller.
- Acts as an AHB-Lite slave upstream and a single-transfer, non-pipelined AHB-Lite master downstream.
- Cache hits complete with zero wait states. Misses fetch a whole line as LINE_WORDS word reads from the XIP controller, which costs roughly 26 HCLK per word.

Parameters:
NUM_LINES, 16, number of cache lines; power of two, 2..64
LINE_WORDS, 4, 32-bit words per line; power of two, 2..8
ADDR_W, 24, flash address bits used for tag/index/offset

Ports:
HCLK  in  1  clock; all logic on rising edge
HRESET  in  1  synchronous, active-high reset
flush  in  1  one-cycle pulse; invalidates all lines
HSEL  in  1  upstream slave select
HREADY  in  1  upstream bus ready
HTRANS  in  2  upstream transfer type
HSIZE  in  3  upstream size; ignored, always a full word is returned
HWRITE  in  1  upstream write flag
HADDR  in  32  upstream address
HREADYOUT  out  1  upstream ready
HRDATA  out  32  upstream read data
M_HSEL  out  1  downstream select; 1 while M_HTRANS is NONSEQ
M_HTRANS  out  2  downstream transfer type; IDLE (00) or NONSEQ (10) only
M_HADDR  out  32  downstream word address; bits [1:0] are always 0
M_HSIZE  out  3  fixed 3'b010
M_HWRITE  out  1  fixed 0
M_HREADY  in  1  downstream ready (XIP HREADYOUT)
M_HRDATA  in  32  downstream read data

Behaviour:
- Address split (OFF = log2(LINE_WORDS*4), IDX = log2(NUM_LINES)):
  - word select = HADDR[OFF-1:2]
  - index = HADDR[OFF+IDX-1:OFF]
  - tag = HADDR[ADDR_W-1:OFF+IDX]
  - HADDR bits [31:ADDR_W] are ignored for lookup and passed through on M_HADDR.
- Storage: tag, valid bit and data words per line, held in flops.
- Reset (HRESET=1 at a clock edge), applies mid-fill as well:
  - state=IDLE; all valid bits cleared; HREADYOUT=1; HRDATA=0
  - M_HTRANS=IDLE; M_HSEL=0; M_HADDR=0
  - any in-progress fill is abandoned with no downstream completion wait.
- Accepted transfer: HSEL & HREADY & HTRANS[1], sampled in IDLE.
- Write, IDLE or BUSY transfer: HREADYOUT=1 next cycle; no state change; write data discarded.
- Read hit (valid & tag match): HRDATA is registered with the selected word at the end of the address phase and HREADYOUT stays 1. Back-to-back hits are zero-wait.
- Read miss: HREADYOUT<=0; captured address, index, tag and word select are latched; go to FADDR with fill counter w=0.
- FSM:
  - IDLE: as above.
  - FADDR: M_HTRANS=NONSEQ, M_HSEL=1, M_HADDR = {captured[31:OFF], w, 2'b00}.
    - If M_HREADY=1, go to FDATA and drive M_HTRANS=IDLE next cycle.
    - Otherwise hold the address phase.
  - FDATA: wait for M_HREADY=1, then write M_HRDATA into line word w.
    - If w = LINE_WORDS-1, go to DONE.
    - Otherwise w++ and go to FADDR.
  - DONE (one cycle): write tag; set valid unless flush was seen during this fill; HRDATA = requested word; HREADYOUT<=1; go to IDLE.
- Miss latency: the requested data is presented once the whole line is filled; there is no critical-word-first.
- Fill order is always word 0 to word LINE_WORDS-1 of the line.
- Flush:
  - In IDLE: all valid bits clear the next cycle. A transfer accepted in that same cycle is looked up against the pre-flush state.
  - During a fill: the fill completes and data is returned to the requester, but the line is not marked valid.
- Replacement: a miss overwrites the indexed line unconditionally.
- Upstream HREADYOUT=0 during a fill holds the upstream bus off, so no new upstream request can arrive during a fill.
- Downstream never issues SEQ, BUSY or writes.

Test Plan:
- Reset then read 0x000100: miss. Exactly 4 NONSEQ reads go out at 0x100, 0x104, 0x108, 0x10C (stub returns 0xA0,0xA1,0xA2,0xA3). HRDATA=0xA0 when HREADYOUT rises.
- Then read 0x000108, 0x00010C, 0x000104 back-to-back: HREADYOUT stays 1, HRDATA = 0xA2, 0xA3, 0xA1, and there is no downstream activity.
- Read 0x000200, which maps to the same index with a different tag: miss and refill. A subsequent read of 0x000100 misses again.
- Stub asserts M_HREADY=0 for 25 cycles per word: word captured only when M_HREADY=1. M_HADDR is held stable throughout FADDR.
- flush pulse mid-fill of 0x000300: data is returned, then a re-read of 0x000300 misses. A flush in IDLE makes the previously cached 0x000100 miss.
- HRESET asserted during FDATA: the next cycle shows HREADYOUT=1, M_HTRANS=00 and all lines invalid. An upstream write to 0x000100 completes zero-wait and causes no downstream access.

Source files
------------

// File: rtl/xip_line_cache.sv
// Read-only direct-mapped line cache between the CPU AHB-Lite bus and the XIP flash controller.
// Hits are zero-wait. A miss holds HREADYOUT low until the whole line has been fetched word by word.
module xip_line_cache #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 24
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        flush,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        M_HSEL,
  output logic [1:0]  M_HTRANS,
  output logic [31:0] M_HADDR,
  output logic [2:0]  M_HSIZE,
  output logic        M_HWRITE,
  input  logic        M_HREADY,
  input  logic [31:0] M_HRDATA
);

  localparam int OFF   = $clog2(LINE_WORDS * 4);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int WS    = OFF - 2;
  localparam int TAG_W = ADDR_W - OFF - IDX;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FADDR = 2'd1;
  localparam logic [1:0] S_FDATA = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WS-1:0] W_LAST = WS'(LINE_WORDS - 1);

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [31:0]          data_d [NUM_LINES][LINE_WORDS];
  logic [31:0]          hrdata_q, hrdata_d;
  logic                 hreadyout_q, hreadyout_d;
  logic [31:2]          cap_q, cap_d;
  logic [WS-1:0]        w_q, w_d;
  logic                 flush_seen_q, flush_seen_d;

  logic [IDX-1:0]   req_idx, cap_idx;
  logic [TAG_W-1:0] req_tag, cap_tag;
  logic [WS-1:0]    req_ws, cap_ws;
  logic             accept, hit;
  logic             unused_ok;

  assign req_ws  = HADDR[OFF-1:2];
  assign req_idx = HADDR[OFF+IDX-1:OFF];
  assign req_tag = HADDR[ADDR_W-1:OFF+IDX];
  assign cap_ws  = cap_q[OFF-1:2];
  assign cap_idx = cap_q[OFF+IDX-1:OFF];
  assign cap_tag = cap_q[ADDR_W-1:OFF+IDX];

  assign accept    = HSEL && HREADY && HTRANS[1];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[1:0]};

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    hrdata_d     = hrdata_q;
    hreadyout_d  = hreadyout_q;
    cap_d        = cap_q;
    w_d          = w_q;
    flush_seen_d = flush_seen_q | flush;

    // Lookups in the flush cycle still see the old valid bits.
    if (flush) begin
      valid_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        hreadyout_d = 1'b1;
        if (accept && !HWRITE) begin
          if (hit) begin
            hrdata_d = data_q[req_idx][req_ws];
          end else begin
            hreadyout_d  = 1'b0;
            cap_d        = HADDR[31:2];
            w_d          = '0;
            flush_seen_d = 1'b0;
            state_d      = S_FADDR;
          end
        end
      end
      S_FADDR: begin
        if (M_HREADY) begin
          state_d = S_FDATA;
        end
      end
      S_FDATA: begin
        if (M_HREADY) begin
          data_d[cap_idx][w_q] = M_HRDATA;
          if (w_q == W_LAST) begin
            state_d = S_DONE;
          end else begin
            w_d     = w_q + WS'(1);
            state_d = S_FADDR;
          end
        end
      end
      default: begin
        tag_d[cap_idx] = cap_tag;
        // A flush anywhere in the fill leaves the line invalid but still serves the requester.
        if (!flush_seen_d) begin
          valid_d[cap_idx] = 1'b1;
        end
        hrdata_d    = data_q[cap_idx][cap_ws];
        hreadyout_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      hrdata_q     <= '0;
      hreadyout_q  <= 1'b1;
      cap_q        <= '0;
      w_q          <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      hrdata_q     <= hrdata_d;
      hreadyout_q  <= hreadyout_d;
      cap_q        <= cap_d;
      w_q          <= w_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  always_ff @(posedge HCLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign HREADYOUT = hreadyout_q;
  assign HRDATA    = hrdata_q;
  assign M_HSEL    = (state_q == S_FADDR);
  assign M_HTRANS  = (state_q == S_FADDR) ? 2'b10 : 2'b00;
  assign M_HADDR   = (state_q == S_FADDR) ? {cap_q[31:OFF], w_q, 2'b00} : 32'h0;
  assign M_HSIZE   = 3'b010;
  assign M_HWRITE  = 1'b0;

endmodule

// File: tb/tb_xip_line_cache.sv
// Directed bench for xip_line_cache with a configurable wait-state XIP slave stub.
module tb_xip_line_cache;

  logic        HCLK = 1'b0;
  logic        HRESET, flush, HSEL, HREADY, HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        M_HSEL, M_HWRITE, M_HREADY;
  logic [1:0]  M_HTRANS;
  logic [31:0] M_HADDR, M_HRDATA;
  logic [2:0]  M_HSIZE;

  int total = 0;
  int bad   = 0;
  int wait_cfg = 0;
  int gap_cfg  = 0;
  logic [31:0] dn_log[$];

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  xip_line_cache #(.NUM_LINES(16), .LINE_WORDS(4), .ADDR_W(24)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .flush(flush),
    .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HADDR(HADDR), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .M_HSEL(M_HSEL), .M_HTRANS(M_HTRANS), .M_HADDR(M_HADDR), .M_HSIZE(M_HSIZE),
    .M_HWRITE(M_HWRITE), .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Flash contents: 0x1xx -> 0xA0.., 0x2xx -> 0xB0.., 0x3xx -> 0xC0.., plus word offset.
  function automatic logic [31:0] stub_data(input logic [31:0] a);
    return 32'h90 + {20'h0, a[11:8], 4'h0} + {28'h0, 2'b00, a[3:2]};
  endfunction

  // Slave stub: wait_cfg low cycles per data phase, gap_cfg extra low cycles after each one.
  initial begin : stub
    logic        acc, done_now, in_dp, hold;
    logic [31:0] acc_a, cur, prev_a;
    int          wl, gl;
    M_HREADY = 1'b1; M_HRDATA = 32'hDEADBEEF;
    in_dp = 1'b0; hold = 1'b0; wl = 0; gl = 0; cur = '0; prev_a = '0; acc_a = '0;
    forever begin
      @(negedge HCLK);
      acc      = (M_HTRANS == 2'b10) && M_HREADY && !HRESET;
      done_now = in_dp && M_HREADY;
      acc_a    = M_HADDR;
      if (M_HTRANS == 2'b10) begin
        if (hold) chk("m_haddr_hold", M_HADDR, prev_a);
        hold   = !M_HREADY;
        prev_a = M_HADDR;
      end else begin
        hold = 1'b0;
      end
      if (acc) begin
        dn_log.push_back(acc_a);
        chk("m_hsel", {31'h0, M_HSEL}, 32'h1);
        chk("m_hwrite", {31'h0, M_HWRITE}, 32'h0);
        chk("m_hsize", {29'h0, M_HSIZE}, 32'h2);
      end
      @(posedge HCLK);
      #1;
      if (done_now) begin
        in_dp = 1'b0;
        gl    = gap_cfg;
      end
      if (acc) begin
        in_dp = 1'b1;
        wl    = wait_cfg;
        cur   = acc_a;
      end
      if (in_dp) begin
        if (wl > 0) begin
          M_HREADY = 1'b0; M_HRDATA = 32'hDEADBEEF; wl--;
        end else begin
          M_HREADY = 1'b1; M_HRDATA = stub_data(cur);
        end
      end else if (gl > 0) begin
        M_HREADY = 1'b0; M_HRDATA = 32'hDEADBEEF; gl--;
      end else begin
        M_HREADY = 1'b1; M_HRDATA = 32'hDEADBEEF;
      end
    end
  end

  // exp_n >= 0: exact wait cycles; -2: any nonzero wait (a miss).
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int exp_n, input bit fl);
    int n;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; flush = fl;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; flush = 1'b0;
    n = 0;
    @(negedge HCLK);
    while (!HREADYOUT && n < 1000) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= 1000) chk($sformatf("rd_timeout_%h", a), 32'h0, 32'h1);
    chk($sformatf("rd_data_%h", a), HRDATA, exp);
    if (exp_n >= 0) chk($sformatf("rd_wait_%h", a), n, exp_n);
    else if (exp_n == -2) chk($sformatf("rd_miss_%h", a), {31'h0, n > 0}, 32'h1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] ba [3];
    logic [31:0] be [3];
    int base, k;
    HRESET = 1'b1; flush = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010;
    HWRITE = 1'b0; HADDR = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_m_htrans", {30'h0, M_HTRANS}, 32'h0);
    chk("rst_m_hsel", {31'h0, M_HSEL}, 32'h0);
    chk("rst_m_haddr", M_HADDR, 32'h0);

    // First miss: 4 words x (FADDR + FDATA) + DONE.
    rd(32'h100, 32'hA0, 9, 1'b0);
    chk("fill_cnt", dn_log.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_addr%0d", i), dn_log[i], 32'h100 + 32'(4 * i));

    ba[0] = 32'h108; ba[1] = 32'h10C; ba[2] = 32'h104;
    be[0] = 32'hA2;  be[1] = 32'hA3;  be[2] = 32'hA1;
    base = dn_log.size();
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = ba[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      if (i < 2) HADDR = ba[i + 1];
      else begin HSEL = 1'b0; HTRANS = 2'b00; end
      @(negedge HCLK);
      chk($sformatf("b2b_rdy%0d", i), {31'h0, HREADYOUT}, 32'h1);
      chk($sformatf("b2b_data%0d", i), HRDATA, be[i]);
    end
    chk("b2b_no_dn", dn_log.size(), base);

    // Same index, different tag evicts and refills.
    rd(32'h200, 32'hB0, 9, 1'b0);
    chk("evict_addr", dn_log[4], 32'h200);
    rd(32'h100, 32'hA0, 9, 1'b0);
    chk("evict_cnt", dn_log.size(), 12);

    // Slow flash: 25 wait states per word and 3 address-phase stall cycles after each word.
    wait_cfg = 25; gap_cfg = 3;
    rd(32'h204, 32'hB1, 118, 1'b0);
    wait_cfg = 0; gap_cfg = 0;
    repeat (6) @(posedge HCLK);

    fork
      rd(32'h308, 32'hC2, 9, 1'b0);
      begin
        repeat (5) @(posedge HCLK);
        #1 flush = 1'b1;
        @(posedge HCLK);
        #1 flush = 1'b0;
      end
    join
    rd(32'h308, 32'hC2, 9, 1'b0);
    rd(32'h30C, 32'hC3, 0, 1'b0);

    rd(32'h100, 32'hA0, 9, 1'b0);
    rd(32'h104, 32'hA1, 0, 1'b0);
    rd(32'h108, 32'hA2, 0, 1'b1);
    rd(32'h100, 32'hA0, 9, 1'b0);

    rd(32'h020, 32'h90, 9, 1'b0);
    rd(32'h024, 32'h91, 0, 1'b0);

    // Reset in the middle of a slow data phase.
    wait_cfg = 25;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h040;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    base = dn_log.size(); k = 0;
    while (dn_log.size() == base && k < 100) begin
      @(posedge HCLK);
      k++;
    end
    chk("rst_fill_started", {31'h0, dn_log.size() > base}, 32'h1);
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    wait_cfg = 0;
    @(negedge HCLK);
    chk("mid_rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("mid_rst_m_htrans", {30'h0, M_HTRANS}, 32'h0);
    chk("mid_rst_hrdata", HRDATA, 32'h0);

    base = dn_log.size();
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h100;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    @(negedge HCLK);
    chk("wr_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    repeat (4) @(negedge HCLK);
    chk("wr_no_dn", dn_log.size(), base);

    rd(32'h024, 32'h91, -2, 1'b0);
    rd(32'h100, 32'hA0, -2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
